ps2_letter_rx: RTL and testbench

PS/2 keyboard receiver feeding the hangman datapath's char/guess inputs. It deserialises PS/2 device-to-host frames, validates start, parity and stop bits, and filters out break and extended sequences. It maps scan-code-set-2 make codes to 5-bit letter codes. Results are presented on a single-entry valid/ready holding register that the control FSM drains.

---
 rtl/ps2_letter_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_letter_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_letter_rx.sv
// PS/2 keyboard receiver for the hangman datapath.
// Synchronises the PS/2 clock and data pins, deserialises device-to-host frames,
// checks start, parity and stop bits, and drops break (F0) and extended (E0)
// sequences. Surviving scan-code-set-2 make codes are mapped to 5-bit letter
// codes and held in a single-entry valid/ready register.
module ps2_letter_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       letter_ready,
  output logic       letter_valid,
  output logic [4:0] letter,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchroniser chains: bit 0 samples the pin, the top bit is the synced value.
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            break_q, break_d;
  logic            ext_q, ext_d;

  logic            valid_q, valid_d;
  logic [4:0]      letter_q, letter_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            clk_s;
  logic            dat_s;
  logic            fall;
  logic            new_code;
  logic [4:0]      new_letter;
  logic [4:0]      lookup_code;
  logic            xfer;

  // Scan-code-set-2 make code to letter code; 0 means "not a key we report".
  function automatic logic [4:0] lookup(input logic [7:0] b);
    logic [4:0] code;
    case (b)
      8'h1C: code = 5'd1;
      8'h32: code = 5'd2;
      8'h21: code = 5'd3;
      8'h23: code = 5'd4;
      8'h24: code = 5'd5;
      8'h2B: code = 5'd6;
      8'h34: code = 5'd7;
      8'h33: code = 5'd8;
      8'h43: code = 5'd9;
      8'h3B: code = 5'd10;
      8'h42: code = 5'd11;
      8'h4B: code = 5'd12;
      8'h3A: code = 5'd13;
      8'h31: code = 5'd14;
      8'h44: code = 5'd15;
      8'h4D: code = 5'd16;
      8'h15: code = 5'd17;
      8'h2D: code = 5'd18;
      8'h1B: code = 5'd19;
      8'h2C: code = 5'd20;
      8'h3C: code = 5'd21;
      8'h2A: code = 5'd22;
      8'h1D: code = 5'd23;
      8'h22: code = 5'd24;
      8'h35: code = 5'd25;
      8'h1A: code = 5'd26;
      8'h5A: code = 5'd27;
      8'h66: code = 5'd28;
      default: code = 5'd0;
    endcase
    return code;
  endfunction

  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign dat_s       = dat_sync_q[SYNC_STAGES-1];
  assign fall        = clk_prev_q & ~clk_s;
  assign xfer        = valid_q & letter_ready;
  assign lookup_code = lookup(shift_q);

  // Next-state logic: synchroniser shift, frame FSM, timeout, decode, handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the branches
    // below leaves one unassigned, which would infer a latch.
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    break_d      = break_q;
    ext_d        = ext_q;
    valid_d      = valid_q;
    letter_d     = letter_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    new_code     = 1'b0;
    new_letter   = 5'd0;

    // Idle-time counter: any falling edge or sitting in IDLE restarts it.
    if (fall || state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          // A 1 on the data line here is a spurious edge, not a start bit.
          if (!dat_s) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end
        end
        DATA: begin
          shift_d = {dat_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s) begin
            frame_err_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            parity_err_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            break_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (break_q || ext_q) begin
            // Tail byte of a release or extended sequence: swallow it.
            break_d = 1'b0;
            ext_d   = 1'b0;
          end else if (lookup_code != 5'd0) begin
            new_code   = 1'b1;
            new_letter = lookup_code;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    // Single-entry holding register: a new code may replace the held one only
    // in the cycle the held one is taken.
    if (new_code) begin
      if (!valid_q || xfer) begin
        valid_d  = 1'b1;
        letter_d = new_letter;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State registers, including the synchroniser flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the synchroniser is reset to 0 too; with the previous-clock flop
      // also 0, the chain filling with an idle-high line cannot look like a
      // falling edge after reset.
      clk_sync_q   <= '0;
      dat_sync_q   <= '0;
      clk_prev_q   <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= 8'd0;
      cnt_q        <= 3'd0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      valid_q      <= 1'b0;
      letter_q     <= 5'd0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      break_q      <= break_d;
      ext_q        <= ext_d;
      valid_q      <= valid_d;
      letter_q     <= letter_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign letter_valid = valid_q;
  assign letter       = letter_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ps2_letter_rx.sv
// Directed bench for ps2_letter_rx: drives PS/2 frames bit by bit and checks
// delivered letters, error pulses, handshake behaviour, timeout and reset.
module tb_ps2_letter_rx;

  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HP   = 8;    // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       letter_ready = 1'b0;
  logic       letter_valid;
  logic [4:0] letter;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  ps2_letter_rx #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .letter_ready(letter_ready),
    .letter_valid(letter_valid),
    .letter      (letter),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Cycle counter and output monitor, sampled on the falling clk edge.
  int   cyc = 0;
  int   got_q[$];
  int   perr_cnt = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt  = 0;
  int   vrun = 0;
  int   last_vrun = 0;
  int   rise_cyc = 0;
  logic vprev = 1'b0;
  int   last_fall_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (letter_valid && letter_ready) got_q.push_back(int'(letter));
    if (parity_err) perr_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (letter_valid) vrun++;
    else begin
      if (vrun != 0) last_vrun = vrun;
      vrun = 0;
    end
    if (letter_valid && !vprev) rise_cyc = cyc;
    vprev = letter_valid;
  end

  function automatic int got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return -1;
  endfunction

  // Send the first n bits of a frame, LSB of the vector first.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  // Full frame; the correct parity bit makes data+parity hold an odd number of ones.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({stop, p, b, 1'b0}, 11);
    repeat (10) @(posedge clk);
    #1;
  endtask

  int base, pbase, fbase, obase;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(letter_valid), 0);
    check("rst_letter", int'(letter), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: single good 1C, ready high
    letter_ready = 1'b1;
    base = got_q.size(); pbase = perr_cnt; fbase = ferr_cnt; obase = ovr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_count", got_q.size() - base, 1);
    check("t1_letter", got_at(base), 1);
    check("t1_latency", rise_cyc - last_fall_cyc, 3);
    check("t1_valid_width", last_vrun, 1);
    check("t1_perr", perr_cnt - pbase, 0);
    check("t1_ferr", ferr_cnt - fbase, 0);
    check("t1_ovr", ovr_cnt - obase, 0);

    // 2: press/release filtering, extended key filtering
    base = got_q.size();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t2_count", got_q.size() - base, 2);
    check("t2_first", got_at(base), 1);
    check("t2_enter", got_at(base + 1), 27);
    base = got_q.size();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h1A, 1'b0, 1'b1);
    check("t2_ext_count", got_q.size() - base, 1);
    check("t2_ext_letter", got_at(base), 26);

    // 3: bad parity, bad stop, then a good frame
    base = got_q.size(); pbase = perr_cnt; fbase = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t3_perr", perr_cnt - pbase, 1);
    check("t3_perr_nolet", got_q.size() - base, 0);
    check("t3_perr_noferr", ferr_cnt - fbase, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3_ferr", ferr_cnt - fbase, 1);
    check("t3_ferr_nolet", got_q.size() - base, 0);
    send_frame(8'h32, 1'b0, 1'b1);
    check("t3_good_count", got_q.size() - base, 1);
    check("t3_good_letter", got_at(base), 2);
    check("t3_perr_total", perr_cnt - pbase, 1);
    check("t3_ferr_total", ferr_cnt - fbase, 1);

    // 4: backpressure and overrun
    letter_ready = 1'b0;
    base = got_q.size(); obase = ovr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_valid_held", int'(letter_valid), 1);
    check("t4_letter_held", int'(letter), 1);
    send_frame(8'h32, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_ovr", ovr_cnt - obase, 1);
    check("t4_valid_after_ovr", int'(letter_valid), 1);
    check("t4_letter_after_ovr", int'(letter), 1);
    @(posedge clk);
    #1 letter_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_xfer_count", got_q.size() - base, 1);
    check("t4_xfer_letter", got_at(base), 1);
    check("t4_valid_cleared", int'(letter_valid), 0);

    // 5: partial frame then timeout
    base = got_q.size(); fbase = ferr_cnt;
    send_bits({2'b11, 8'h24, 1'b0}, 5);
    repeat (TMO - 30) @(posedge clk);
    check("t5_no_early_ferr", ferr_cnt - fbase, 0);
    repeat (60) @(posedge clk);
    #1;
    check("t5_timeout_ferr", ferr_cnt - fbase, 1);
    check("t5_no_letter", got_q.size() - base, 0);
    send_frame(8'h24, 1'b0, 1'b1);
    check("t5_next_count", got_q.size() - base, 1);
    check("t5_next_letter", got_at(base), 5);

    // 6: reset mid-frame with a code held, then a fresh frame
    letter_ready = 1'b0;
    send_frame(8'h2B, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_pre_valid", int'(letter_valid), 1);
    check("t6_pre_letter", int'(letter), 6);
    send_bits({2'b11, 8'h3C, 1'b0}, 4);
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", int'(letter_valid), 0);
    check("t6_rst_letter", int'(letter), 0);
    check("t6_rst_perr", int'(parity_err), 0);
    check("t6_rst_ferr", int'(frame_err), 0);
    check("t6_rst_ovr", int'(overrun), 0);
    @(posedge clk);
    #1 letter_ready = 1'b1;
    base = got_q.size();
    send_frame(8'h15, 1'b0, 1'b1);
    check("t6_next_count", got_q.size() - base, 1);
    check("t6_next_letter", got_at(base), 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
